// File: rtl/seg_fill_engine_if.sv
// Command, control and display bundle for seg_fill_engine.
// The master side issues fill commands; the slave side is the engine.
interface seg_fill_engine_if #(
   parameter int NUM_DIGITS = 6,
   parameter int SIZE_W     = 3,
   parameter int VEC_W      = 3,
   parameter int DEPTH_LOG  = 3
);
   logic                    cmd_valid;
   logic                    cmd_ready;
   logic [SIZE_W-1:0]       cmd_size;
   logic [VEC_W-1:0]        cmd_vectors;
   logic [3:0]              cmd_digit;
   logic                    pause;
   logic [7*NUM_DIGITS-1:0] seg;
   logic                    busy;
   logic                    done;
   logic                    drop;
   logic [DEPTH_LOG:0]      cmd_count;

   modport master (
      output cmd_valid, cmd_size, cmd_vectors, cmd_digit, pause,
      input  cmd_ready, seg, busy, done, drop, cmd_count
   );

   modport slave (
      input  cmd_valid, cmd_size, cmd_vectors, cmd_digit, pause,
      output cmd_ready, seg, busy, done, drop, cmd_count
   );
endinterface

// File: rtl/seg_fill_engine.sv
// Seven-segment fill engine: queues fill commands in a show-ahead FIFO and
// plays each one as beats of lit vectors across active-low digits, then a blank beat.
module seg_fill_engine #(
   parameter int NUM_DIGITS     = 6,
   parameter int DIGITS_PER_VEC = 2,
   parameter int SIZE_W         = 3,
   parameter int VEC_W          = 3,
   parameter int DEPTH_LOG      = 3
) (
   input logic              clk,
   input logic              reset,
   seg_fill_engine_if.slave bus_io
);
   localparam int VPB     = NUM_DIGITS / DIGITS_PER_VEC;
   localparam int DEPTH   = 2 ** DEPTH_LOG;
   localparam int ENTRY_W = SIZE_W + VEC_W + 4;
   localparam logic [DEPTH_LOG:0] FULL_CNT  = (DEPTH_LOG + 1)'(DEPTH);
   localparam logic [6:0]         SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHOW  = 2'd1,
      ST_BLANK = 2'd2
   } state_t;

   function automatic logic [6:0] decode_hex(input logic [3:0] v);
      case (v)
         4'h0:    decode_hex = 7'b1000000;
         4'h1:    decode_hex = 7'b1111001;
         4'h2:    decode_hex = 7'b0100100;
         4'h3:    decode_hex = 7'b0110000;
         4'h4:    decode_hex = 7'b0011001;
         4'h5:    decode_hex = 7'b0010010;
         4'h6:    decode_hex = 7'b0000010;
         4'h7:    decode_hex = 7'b1111000;
         4'h8:    decode_hex = 7'b0000000;
         4'h9:    decode_hex = 7'b0010000;
         4'hA:    decode_hex = 7'b0001000;
         4'hB:    decode_hex = 7'b0000011;
         4'hC:    decode_hex = 7'b1000110;
         4'hD:    decode_hex = 7'b0100001;
         4'hE:    decode_hex = 7'b0000110;
         4'hF:    decode_hex = 7'b0001110;
         default: decode_hex = SEG_BLANK;
      endcase
   endfunction

   // Vectors lit in a beat: the remaining count, capped at one full display.
   function automatic logic [VEC_W-1:0] lit_vecs(input logic [VEC_W-1:0] rem);
      if (int'(rem) > VPB) lit_vecs = VEC_W'(VPB);
      else                 lit_vecs = rem;
   endfunction

   logic [ENTRY_W-1:0]      mem_q [DEPTH];
   logic [DEPTH_LOG-1:0]    wr_ptr_q, rd_ptr_q;
   logic [DEPTH_LOG:0]      count_q, count_d;
   logic                    ready_s, push_s, pop_s;
   logic [ENTRY_W-1:0]      head_s;
   logic [SIZE_W-1:0]       head_size_s;
   logic [VEC_W-1:0]        head_vec_s;
   logic [3:0]              head_dig_s;

   state_t                  state_q, state_d;
   logic [VEC_W-1:0]        rem_q, rem_d, n_s;
   logic [SIZE_W-1:0]       beat_q, beat_d, sz_q, sz_d;
   logic [3:0]              dig_q, dig_d;
   logic [7*NUM_DIGITS-1:0] seg_q, seg_d;
   logic                    busy_q, busy_d, done_q, done_d, drop_q;

   // Slot availability comes from registered occupancy only, so a same-cycle pop never frees room.
   assign ready_s     = (count_q != FULL_CNT);
   assign push_s      = bus_io.cmd_valid & ready_s;
   assign head_s      = mem_q[rd_ptr_q];
   assign head_size_s = head_s[ENTRY_W-1 -: SIZE_W];
   assign head_vec_s  = head_s[4 +: VEC_W];
   assign head_dig_s  = head_s[3:0];

   always_ff @(posedge clk) begin
      if (push_s) mem_q[wr_ptr_q] <= {bus_io.cmd_size, bus_io.cmd_vectors, bus_io.cmd_digit};
   end

   always_comb begin
      count_d = count_q;
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + (DEPTH_LOG + 1)'(1);
         2'b01:   count_d = count_q - (DEPTH_LOG + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= {DEPTH_LOG{1'b0}};
         rd_ptr_q <= {DEPTH_LOG{1'b0}};
         count_q  <= {(DEPTH_LOG + 1){1'b0}};
         drop_q   <= 1'b0;
      end else begin
         if (push_s) wr_ptr_q <= wr_ptr_q + DEPTH_LOG'(1);
         if (pop_s)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG'(1);
         count_q <= count_d;
         drop_q  <= bus_io.cmd_valid & ~ready_s;
      end
   end

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      beat_d  = beat_q;
      sz_d    = sz_q;
      dig_d   = dig_q;
      pop_s   = 1'b0;
      done_d  = 1'b0;
      n_s     = lit_vecs(rem_q);
      if (!bus_io.pause) begin
         case (state_q)
            ST_IDLE: begin
               if (count_q != {(DEPTH_LOG + 1){1'b0}}) begin
                  pop_s  = 1'b1;
                  sz_d   = head_size_s;
                  rem_d  = head_vec_s;
                  dig_d  = head_dig_s;
                  beat_d = SIZE_W'(1);
                  // Empty commands complete immediately without lighting anything.
                  if (head_size_s == {SIZE_W{1'b0}} || head_vec_s == {VEC_W{1'b0}}) begin
                     done_d = 1'b1;
                  end else begin
                     state_d = ST_SHOW;
                  end
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_SHOW: begin
               if (beat_q == sz_q) begin
                  rem_d  = rem_q - n_s;
                  beat_d = SIZE_W'(1);
                  if (rem_d == {VEC_W{1'b0}}) state_d = ST_BLANK;
                  else                        state_d = ST_SHOW;
               end else begin
                  beat_d = beat_q + SIZE_W'(1);
               end
            end
            ST_BLANK: begin
               if (beat_q == sz_q) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  beat_d = beat_q + SIZE_W'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Display is registered from next-state values so it tracks the state it belongs to.
   always_comb begin
      seg_d  = {(7 * NUM_DIGITS){1'b1}};
      busy_d = (state_d != ST_IDLE);
      if (state_d == ST_SHOW) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((i / DIGITS_PER_VEC) < int'(lit_vecs(rem_d))) seg_d[7*i +: 7] = decode_hex(dig_d);
            else                                              seg_d[7*i +: 7] = SEG_BLANK;
         end
      end else begin
         seg_d = {(7 * NUM_DIGITS){1'b1}};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         rem_q   <= {VEC_W{1'b0}};
         beat_q  <= {SIZE_W{1'b0}};
         sz_q    <= {SIZE_W{1'b0}};
         dig_q   <= 4'h0;
         seg_q   <= {(7 * NUM_DIGITS){1'b1}};
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         beat_q  <= beat_d;
         sz_q    <= sz_d;
         dig_q   <= dig_d;
         seg_q   <= seg_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus_io.cmd_ready = ready_s;
   assign bus_io.cmd_count = count_q;
   assign bus_io.seg       = seg_q;
   assign bus_io.busy      = busy_q;
   assign bus_io.done      = done_q;
   assign bus_io.drop      = drop_q;
endmodule

// File: tb/tb_seg_fill_engine.sv
// Directed bench for seg_fill_engine: default six-digit instance plus an
// eight-digit, one-digit-per-vector instance; outputs sampled on the falling edge.
module tb_seg_fill_engine;
   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   seg_fill_engine_if #(.NUM_DIGITS(6)) if6 ();
   seg_fill_engine_if #(.NUM_DIGITS(8)) if8 ();

   seg_fill_engine #(.NUM_DIGITS(6), .DIGITS_PER_VEC(2)) dut (
      .clk(clk), .reset(reset), .bus_io(if6.slave)
   );
   seg_fill_engine #(.NUM_DIGITS(8), .DIGITS_PER_VEC(1)) dut8 (
      .clk(clk), .reset(reset), .bus_io(if8.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h1:    hex7 = 7'b1111001;
         4'h2:    hex7 = 7'b0100100;
         4'h3:    hex7 = 7'b0110000;
         4'h4:    hex7 = 7'b0011001;
         4'h5:    hex7 = 7'b0010010;
         4'h6:    hex7 = 7'b0000010;
         4'h7:    hex7 = 7'b1111000;
         4'h8:    hex7 = 7'b0000000;
         4'h9:    hex7 = 7'b0010000;
         4'hF:    hex7 = 7'b0001110;
         default: hex7 = 7'b1111111;
      endcase
   endfunction

   // Expected segment word: the lowest nlit digits show pat, the rest are blank.
   function automatic logic [63:0] segs(input int ndig, input logic [6:0] pat, input int nlit);
      logic [63:0] r;
      r = 64'h0;
      for (int i = 0; i < ndig; i++) r[7*i +: 7] = (i < nlit) ? pat : 7'b1111111;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push6(input logic [2:0] s, input logic [2:0] v, input logic [3:0] d);
      if6.cmd_valid   = 1'b1;
      if6.cmd_size    = s;
      if6.cmd_vectors = v;
      if6.cmd_digit   = d;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   logic [63:0] blank6;
   logic [63:0] blank8;
   int          acc;

   initial begin
      n_cmp = 0;
      n_err = 0;
      blank6 = segs(6, 7'b1111111, 0);
      blank8 = segs(8, 7'b1111111, 0);
      reset = 1'b0;
      if6.cmd_valid = 1'b0; if6.cmd_size = 3'd0; if6.cmd_vectors = 3'd0; if6.cmd_digit = 4'h0; if6.pause = 1'b0;
      if8.cmd_valid = 1'b0; if8.cmd_size = 3'd0; if8.cmd_vectors = 3'd0; if8.cmd_digit = 4'h0; if8.pause = 1'b0;
      tick(); tick();

      chk("rst_seg", 64'(if6.seg), blank6);
      chk("rst_busy", 64'(if6.busy), 64'd0);
      chk("rst_done", 64'(if6.done), 64'd0);
      chk("rst_drop", 64'(if6.drop), 64'd0);
      chk("rst_count", 64'(if6.cmd_count), 64'd0);
      chk("rst_ready", 64'(if6.cmd_ready), 64'd1);
      reset = 1'b1;
      tick();

      // Basic fill: size 2, vectors 4, digit 1.
      push6(3'd2, 3'd4, 4'h1);
      tick();
      if6.cmd_valid = 1'b0;
      chk("t1_count", 64'(if6.cmd_count), 64'd1);
      chk("t1_idle", 64'(if6.busy), 64'd0);
      acc = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         acc += int'(if6.busy);
         if (c < 2)      chk("t1_full", 64'(if6.seg), segs(6, 7'b1111001, 6));
         else if (c < 4) chk("t1_part", 64'(if6.seg), segs(6, 7'b1111001, 2));
         else            chk("t1_blank", 64'(if6.seg), blank6);
         chk("t1_done", 64'(if6.done), (c == 6) ? 64'd1 : 64'd0);
      end
      chk("t1_busy_cycles", 64'(acc), 64'd6);

      // Zero-vector command is discarded with a done pulse.
      push6(3'd3, 3'd0, 4'hA);
      tick();
      if6.cmd_valid = 1'b0;
      tick();
      chk("t2_done", 64'(if6.done), 64'd1);
      chk("t2_busy", 64'(if6.busy), 64'd0);
      chk("t2_seg", 64'(if6.seg), blank6);
      chk("t2_count", 64'(if6.cmd_count), 64'd0);
      tick();
      chk("t2_done_off", 64'(if6.done), 64'd0);

      // Fill the FIFO while paused, then overflow once.
      if6.pause = 1'b1;
      for (int k = 0; k < 8; k++) begin
         push6(3'd1, 3'd1, 4'(k + 2));
         tick();
         chk("t3_fill_count", 64'(if6.cmd_count), 64'(k + 1));
      end
      chk("t3_full_ready", 64'(if6.cmd_ready), 64'd0);
      push6(3'd1, 3'd1, 4'h1);
      tick();
      if6.cmd_valid = 1'b0;
      chk("t3_drop", 64'(if6.drop), 64'd1);
      chk("t3_drop_count", 64'(if6.cmd_count), 64'd8);
      chk("t3_paused_busy", 64'(if6.busy), 64'd0);
      tick();
      chk("t3_drop_off", 64'(if6.drop), 64'd0);
      if6.pause = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("t3_order_seg", 64'(if6.seg), segs(6, hex7(4'(k + 2)), 2));
         tick();
         chk("t3_order_blank", 64'(if6.seg), blank6);
         tick();
         chk("t3_order_done", 64'(if6.done), 64'd1);
      end
      chk("t3_empty", 64'(if6.cmd_count), 64'd0);

      // Two back-to-back commands, with a pause in the middle of the second.
      push6(3'd1, 3'd3, 4'h7);
      tick();
      push6(3'd1, 3'd6, 4'hF);
      tick();
      if6.cmd_valid = 1'b0;
      chk("t4_a_seg", 64'(if6.seg), segs(6, 7'b1111000, 6));
      tick();
      chk("t4_a_blank", 64'(if6.seg), blank6);
      chk("t4_a_busy", 64'(if6.busy), 64'd1);
      tick();
      chk("t4_a_done", 64'(if6.done), 64'd1);
      chk("t4_gap_busy", 64'(if6.busy), 64'd0);
      tick();
      chk("t4_b_beat1", 64'(if6.seg), segs(6, 7'b0001110, 6));
      if6.pause = 1'b1;
      tick();
      chk("t4_b_hold", 64'(if6.seg), segs(6, 7'b0001110, 6));
      chk("t4_b_hold_busy", 64'(if6.busy), 64'd1);
      if6.pause = 1'b0;
      tick();
      chk("t4_b_beat2", 64'(if6.seg), segs(6, 7'b0001110, 6));
      chk("t4_b_nodone", 64'(if6.done), 64'd0);
      tick();
      chk("t4_b_blank", 64'(if6.seg), blank6);
      tick();
      chk("t4_b_done", 64'(if6.done), 64'd1);
      tick();

      // Reset mid-SHOW with three commands queued.
      push6(3'd3, 3'd6, 4'h5);
      tick();
      push6(3'd1, 3'd1, 4'h1);
      tick();
      push6(3'd1, 3'd1, 4'h2);
      tick();
      push6(3'd1, 3'd1, 4'h3);
      tick();
      if6.cmd_valid = 1'b0;
      chk("t5_pre_count", 64'(if6.cmd_count), 64'd3);
      chk("t5_pre_seg", 64'(if6.seg), segs(6, 7'b0010010, 6));
      reset = 1'b0;
      tick();
      chk("t5_seg", 64'(if6.seg), blank6);
      chk("t5_busy", 64'(if6.busy), 64'd0);
      chk("t5_count", 64'(if6.cmd_count), 64'd0);
      reset = 1'b1;
      acc = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         acc += int'(if6.busy) + int'(if6.done);
      end
      chk("t5_quiet", 64'(acc), 64'd0);

      // Eight digits, one per vector: seven lit, top digit blank.
      if8.cmd_valid = 1'b1; if8.cmd_size = 3'd1; if8.cmd_vectors = 3'd7; if8.cmd_digit = 4'h9;
      tick();
      if8.cmd_valid = 1'b0;
      tick();
      chk("t6_seg", 64'(if8.seg), segs(8, 7'b0010000, 7));
      chk("t6_busy", 64'(if8.busy), 64'd1);
      tick();
      chk("t6_blank", 64'(if8.seg), blank8);
      chk("t6_nodone", 64'(if8.done), 64'd0);
      tick();
      chk("t6_done", 64'(if8.done), 64'd1);
      chk("t6_idle", 64'(if8.busy), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/seg_fill_engine.md
# seg_fill_engine

Parametrised seven-segment fill engine for the board display path. It accepts fill commands (digit value, beat length, vector count) into an internal single-clock command FIFO. It plays each command back as a sequence of fill beats across `NUM_DIGITS` active-low digits, then blanks the display for one beat. Compared with the fixed six-digit / three-vector fill, it adds configurable digit count, vector width, FIFO depth and hex digits, plus pause, completion and overflow signalling.

## Interface
- `NUM_DIGITS`, default 6: number of seven-segment digits driven.
- `DIGITS_PER_VEC`, default 2: digits lit per vector; `NUM_DIGITS` must be a multiple of it.
- `SIZE_W`, default 3: width of beat length `cmd_size`.
- `VEC_W`, default 3: width of vector count `cmd_vectors`.
- `DEPTH_LOG`, default 3: command FIFO holds `2**DEPTH_LOG` entries.
- Derived constant `VPB = NUM_DIGITS/DIGITS_PER_VEC`: vectors shown per beat.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-low.
- `cmd_valid`  in  1  command push request.
- `cmd_ready`  out  1  FIFO not full; a push happens on `cmd_valid & cmd_ready`.
- `cmd_size`  in  `SIZE_W`  beat length in cycles.
- `cmd_vectors`  in  `VEC_W`  number of vectors to display.
- `cmd_digit`  in  4  hex value shown, 0–F.
- `pause`  in  1  freezes playback.
- `seg`  out  `7*NUM_DIGITS`  active-low segments; digit i occupies `[7i+6:7i]`, segment order gfedcba.
- `busy`  out  1  engine is in the SHOW or BLANK state.
- `done`  out  1  one-cycle pulse when a command completes.
- `drop`  out  1  one-cycle pulse when a push is attempted while full.
- `cmd_count`  out  `DEPTH_LOG+1`  current FIFO occupancy.

## Operation
- Decode (active-low, gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - Blank = 1111111.
- FIFO:
  - Show-ahead circular buffer; each entry is {size, vectors, digit}.
  - `cmd_ready = (cmd_count != 2**DEPTH_LOG)`, computed from registered occupancy only.
  - A pop in the same cycle does not free a slot for a push in that cycle.
  - Simultaneous push and pop leaves `cmd_count` unchanged.
  - Pointers wrap modulo depth.
- FSM states: IDLE, SHOW, BLANK. Registers: `rem` (`VEC_W`), `beat` (`SIZE_W`), `sz`, `dig`.
- IDLE:
  - `seg` is all blank and `busy`=0.
  - If the FIFO is non-empty and `pause`=0, pop the head and latch `sz`, `rem`, `dig`.
  - If the popped `size`==0 or `vectors`==0, discard it: pulse `done` the next cycle and stay in IDLE.
  - Otherwise go to SHOW with `beat`=1.
- SHOW:
  - Lit vectors `n = min(rem, VPB)`.
  - Digits 0 .. `n*DIGITS_PER_VEC-1` show `dig`; the remaining digits are blank.
  - When `beat==sz`: set `rem -= n` and `beat`=1. If the new `rem`==0, go to BLANK; otherwise stay in SHOW.
  - When `beat!=sz`: `beat++`.
- BLANK:
  - All digits are blank for `sz` cycles.
  - Then go to IDLE and assert `done` for one cycle, in that first IDLE cycle.
- `pause`=1 holds the state, `beat`, `rem` and `seg`, and blocks pops. FIFO pushes still proceed.
- `drop` pulses one cycle after any cycle with `cmd_valid & ~cmd_ready`. The command is lost and `cmd_count` is unchanged.

## Timing
- Reset (`reset`=0 at a clk edge):
  - FIFO emptied; `cmd_count`=0, `cmd_ready`=1.
  - State IDLE; `seg` all 1s; `busy`=0, `done`=0, `drop`=0.
  - Applies from any state, including mid-beat; in-flight and queued commands are discarded.
- All outputs are registered except `cmd_ready`, which is decoded from the `cmd_count` register.
- Push at edge t into an empty FIFO with the engine idle:
  - Pop at edge t+1.
  - `seg` shows beat 1 and `busy`=1 from edge t+1.
- Active duration of a command = `size*(ceil(vectors/VPB)+1)` cycles, excluding pauses.
- `done` rises at the edge that ends BLANK.
- The next queued command is popped at the following edge, so there is one blank IDLE cycle between commands.

## Test plan
- Defaults, push size=2, vectors=4, digit=1:
  - 2 cycles with all 6 digits =1111001.
  - 2 cycles with digits 0–1 =1111001 and digits 2–5 blank.
  - 2 blank cycles.
  - `done` pulse; `busy` high exactly 6 cycles.
- Push size=3, vectors=0, digit=A:
  - Popped next cycle and `done` pulses once.
  - `busy` stays 0 and `seg` stays all blank.
- Hold `pause`=1 and push 9 commands:
  - `cmd_count` reaches 8 and `cmd_ready`=0 after the 8th.
  - `drop` pulses once for the 9th.
  - Release `pause`: the 8 commands play in push order.
- Push two commands (size=1, vectors=3, digit=7; size=1, vectors=6, digit=F):
  - First: 1 beat with all digits 7, then blank.
  - One idle cycle.
  - Second: 2 beats of F, then blank.
  - Two `done` pulses.
- Assert `reset`=0 mid-SHOW with 3 commands queued:
  - Next cycle `seg` is all blank, `busy`=0, `cmd_count`=0.
  - Nothing plays after reset is released.
- With `NUM_DIGITS`=8, `DIGITS_PER_VEC`=1, size=1, vectors=7, digit=9:
  - One beat with digits 0–6 =0010000 and digit 7 blank.
  - Then blank, then `done`.
